// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    localparam int unsigned INSTR_BYTES = 4;
    localparam int unsigned PC_RESET    = 0;
endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction-memory request/response bus between fetch (master) and memory (slave).
interface instruction_fetch_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (output req, output addr, input gnt, input rvalid, input rdata);
    modport slave  (input req, input addr, output gnt, output rvalid, output rdata);
endinterface

// File: rtl/instruction_fetch_fifo.sv
// Synchronous FIFO of {pc, instr} entries; head reads as zero while empty.
module fetch_fifo #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 64,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             clear,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] head
);
    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_pop;
    logic             do_push;

    assign do_pop  = pop && (count_reg != '0);
    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign do_push = push && ((count_reg < CNT_W'(DEPTH)) || do_pop);

    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    assign count = count_reg;
    assign head  = (count_reg != '0) ? mem_reg[rd_ptr_reg] : '0;
endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: one outstanding imem request, buffered {pc, instr} toward decode.
// Optional alignment check enabled by defining IF_MISALIGN_CHECK_EN.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [ADDR_W-1:0]    pc,
    output logic [ADDR_W-1:0]    next_pc,
    output logic                 pc_en,
    input  logic                 flush,
    instruction_fetch_if.master  imem,
    output logic                 if_valid,
    output logic [DATA_W-1:0]    if_instr,
    output logic [ADDR_W-1:0]    if_pc,
    input  logic                 id_ready
`ifdef IF_MISALIGN_CHECK_EN
    ,
    output logic                 if_misalign
`endif
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t             state_reg;
    logic [ADDR_W-1:0]        req_pc_reg;
    logic [CNT_W-1:0]         fifo_count;
    logic [ADDR_W+DATA_W-1:0] fifo_head;
    logic [CNT_W:0]           occupancy;
    logic                     space;
    logic                     pop;
    logic                     push;
    logic                     accept;
    logic                     aligned;

`ifdef IF_MISALIGN_CHECK_EN
    logic misalign_reg;

    assign aligned     = (pc[1:0] == 2'b00);
    assign if_misalign = misalign_reg;

    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            misalign_reg <= 1'b0;
        end else if (state_reg == IDLE && !aligned) begin
            misalign_reg <= 1'b1;
        end
    end
`else
    assign aligned = 1'b1;
`endif

    assign pop       = if_valid && id_ready;
    // An in-flight fetch reserves a FIFO slot before its data returns.
    assign occupancy = (CNT_W+1)'(fifo_count) + (CNT_W+1)'(state_reg != IDLE) - (CNT_W+1)'(pop);
    assign space     = occupancy < (CNT_W+1)'(FIFO_DEPTH);

    assign imem.req  = reset_n && (state_reg == IDLE) && space && !flush && aligned;
    assign imem.addr = pc;
    assign accept    = imem.req && imem.gnt;
    assign pc_en     = reset_n && (accept || flush);
    assign next_pc   = pc + ADDR_W'(INSTR_BYTES);

    assign push      = (state_reg == WAIT) && imem.rvalid && !flush;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg  <= IDLE;
            req_pc_reg <= ADDR_W'(PC_RESET);
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        state_reg  <= WAIT;
                        req_pc_reg <= pc;
                    end
                end
                WAIT: begin
                    if (imem.rvalid)  state_reg <= IDLE;
                    else if (flush)   state_reg <= DROP;
                end
                DROP: begin
                    if (imem.rvalid)  state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ADDR_W + DATA_W)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data ({req_pc_reg, imem.rdata}),
        .pop       (pop),
        .clear     (flush),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    assign if_valid = (fifo_count != '0);
    assign if_pc    = fifo_head[ADDR_W+DATA_W-1:DATA_W];
    assign if_instr = fifo_head[DATA_W-1:0];
endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a queue-based reference model and memory responder.
module tb_instruction_fetch;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic        pc_en;
    logic        flush;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready;
`ifdef IF_MISALIGN_CHECK_EN
    logic        if_misalign;
`endif

    instruction_fetch_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    instruction_fetch #(.ADDR_W(32), .DATA_W(32), .FIFO_DEPTH(2)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .pc       (pc),
        .next_pc  (next_pc),
        .pc_en    (pc_en),
        .flush    (flush),
        .imem     (bus),
        .if_valid (if_valid),
        .if_instr (if_instr),
        .if_pc    (if_pc),
        .id_ready (id_ready)
`ifdef IF_MISALIGN_CHECK_EN
        ,
        .if_misalign (if_misalign)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: expected FIFO contents plus the one in-flight fetch.
    logic [63:0] m_q[$];
    bit          m_live  = 1'b0;
    bit          m_stale = 1'b0;
    bit          m_mis   = 1'b0;
    logic [31:0] m_req_pc = '0;
    bit          model_ok = 1'b0;

    // Memory responder state
    bit          pend = 1'b0;
    int          resp_wait = 0;
    int          lat = 1;
    logic [31:0] resp_data = '0;
    logic [31:0] jump_pc = '0;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[23:0], 8'h13};
    endfunction

    function automatic bit model_req();
        int occ;
        bit r;
        occ = m_q.size() - (((m_q.size() != 0) && id_ready) ? 1 : 0);
        r = reset_n && !m_live && !m_stale && (occ < 2) && !flush;
`ifdef IF_MISALIGN_CHECK_EN
        r = r && (pc[1:0] == 2'b00);
`endif
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (model_ok) begin
            logic [63:0] h;
            bit ev, er;
            ev = (m_q.size() != 0);
            er = model_req();
            chk("if_valid", 32'(if_valid), 32'(ev));
            if (ev) begin
                h = m_q[0];
                chk("if_pc", if_pc, h[63:32]);
                chk("if_instr", if_instr, h[31:0]);
                if (id_ready) $display("pop pc=%h instr=%h", if_pc, if_instr);
            end
            chk("imem_req", 32'(bus.req), 32'(er));
            chk("pc_en", 32'(pc_en), 32'(reset_n && ((er && bus.gnt) || flush)));
            chk("next_pc", next_pc, pc + 32'd4);
            chk("imem_addr", bus.addr, pc);
`ifdef IF_MISALIGN_CHECK_EN
            chk("if_misalign", 32'(if_misalign), 32'(m_mis));
`endif
        end
    end

    // Advance one clock; model and PC register update just after the edge.
    task automatic tick();
        bit rst_c, fl_c, rv_c, req_c, pop_c, gnt_c;
        logic [31:0] pc_c, rd_c;
        rst_c = reset_n; fl_c = flush; rv_c = bus.rvalid; rd_c = bus.rdata;
        pc_c = pc; gnt_c = bus.gnt;
        req_c = model_req();
        pop_c = (m_q.size() != 0) && id_ready;
        @(posedge clk);
        #1;
        if (!rst_c) begin
            m_q.delete();
            m_live = 0; m_stale = 0; m_mis = 0;
            model_ok = 1'b1;
        end else begin
            if (pop_c) void'(m_q.pop_front());
            if (m_live && rv_c) begin
                if (!fl_c) m_q.push_back({m_req_pc, rd_c});
                m_live = 0;
            end else if (m_live && fl_c) begin
                m_live = 0; m_stale = 1;
            end else if (m_stale && rv_c) begin
                m_stale = 0;
            end
            if (fl_c) m_q.delete();
            if (req_c && gnt_c) begin
                m_live = 1; m_req_pc = pc_c;
                pend = 1; resp_wait = lat; resp_data = instr_of(pc_c);
            end
            if (fl_c) m_mis = 0;
            else if (!m_live && !m_stale && !(req_c && gnt_c) && pc_c[1:0] != 2'b00) m_mis = 1;
        end
        if (rst_c && ((req_c && gnt_c) || fl_c)) pc = fl_c ? jump_pc : pc_c + 32'd4;
        bus.rvalid = 1'b0;
        bus.rdata  = 32'hDEAD_BEEF;
        if (pend) begin
            if (resp_wait <= 1) begin
                bus.rvalid = 1'b1; bus.rdata = resp_data; pend = 0;
            end else begin
                resp_wait--;
            end
        end
    endtask

    task automatic wait_live();
        int n = 0;
        while (!m_live && n < 20) begin tick(); n++; end
        total++;
        if (!m_live) begin bad++; $display("FAIL wait_live: got=0 want=1 at t=%0t", $time); end
    endtask

    task automatic do_flush(input logic [31:0] target);
        flush = 1'b1; jump_pc = target;
        tick();
        flush = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; flush = 1'b1; id_ready = 1'b0; pc = '0;
        bus.gnt = 1'b1; bus.rvalid = 1'b0; bus.rdata = '0;

        // Reset: outputs quiet even with flush asserted
        tick(); tick(); #1;
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_if_instr", if_instr, 32'd0);
        chk("rst_if_pc", if_pc, 32'd0);
        chk("rst_imem_req", 32'(bus.req), 32'd0);
        chk("rst_pc_en", 32'(pc_en), 32'd0);

        // First fetch: grant cycle 1, rvalid cycle 2, if_valid cycle 3
        flush = 1'b0; reset_n = 1'b1; #1;
        chk("c1_next_pc", next_pc, 32'h4);
        chk("c1_pc_en", 32'(pc_en), 32'd1);
        tick(); #1;
        chk("c2_pc_en", 32'(pc_en), 32'd0);
        chk("c2_if_valid", 32'(if_valid), 32'd0);
        tick(); #1;
        chk("c3_if_valid", 32'(if_valid), 32'd1);
        chk("c3_if_pc", if_pc, 32'h0);
        chk("c3_if_instr", if_instr, 32'h0000_0013);

        // Back-pressure fills the FIFO, then drain in order
        tick(); tick(); tick(); #1;
        chk("full_if_pc", if_pc, 32'h0);
        chk("full_imem_req", 32'(bus.req), 32'd0);
        chk("full_pc_en", 32'(pc_en), 32'd0);
        id_ready = 1'b1; #1;
        chk("drain0_if_pc", if_pc, 32'h0);
        tick(); #1;
        chk("drain1_if_pc", if_pc, 32'h4);
        chk("drain1_if_instr", if_instr, 32'h0000_0413);

        // Flush while waiting on a slow response
        lat = 3;
        wait_live();
        do_flush(32'h100); #1;
        chk("flushw_if_valid", 32'(if_valid), 32'd0);
        lat = 1;
        for (int n = 0; n < 15 && m_q.size() == 0; n++) tick();
        #1;
        chk("redir_if_pc", if_pc, 32'h100);
        chk("redir_if_instr", if_instr, 32'h0001_0013);

        // Flush coinciding with rvalid
        tick();
        wait_live();
        do_flush(32'h200); #1;
        chk("flushr_if_valid", 32'(if_valid), 32'd0);
        chk("flushr_imem_req", 32'(bus.req), 32'd1);

        // PC wrap
        tick(); tick();
        do_flush(32'hFFFF_FFFC); #1;
        chk("wrap_next_pc", next_pc, 32'h0);
        tick(); tick(); tick();

        // Reset during WAIT, late response must be ignored
        lat = 3;
        tick();
        wait_live();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1; pc = '0; bus.gnt = 1'b0;
        tick(); tick(); tick(); tick(); #1;
        chk("late_if_valid", 32'(if_valid), 32'd0);
        chk("late_imem_req", 32'(bus.req), 32'd1);
        bus.gnt = 1'b1; lat = 1;
        tick(); tick(); tick();

`ifdef IF_MISALIGN_CHECK_EN
        do_flush(32'h2);
        tick(); tick(); tick(); tick(); #1;
        chk("mis_imem_req", 32'(bus.req), 32'd0);
        chk("mis_flag", 32'(if_misalign), 32'd1);
        do_flush(32'h0); #1;
        chk("mis_clear", 32'(if_misalign), 32'd0);
        tick(); tick();
`endif

        tick(); tick(); tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
